// File: rtl/jtag_tap.sv
// IEEE 1149.1-style TAP controller stepped by an enable in the clk domain.
// Provides IDCODE, BYPASS and an USER_W-bit user data register.
module jtag_tap #(
  parameter int          IR_W   = 4,
  parameter logic [31:0] IDCODE = 32'h1BA0_0477,
  parameter int          USER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        drive_i,
  output logic [3:0]        state_o,
  output logic              tdo_o,
  output logic [IR_W-1:0]   ir_o,
  output logic [USER_W-1:0] user_dr_o,
  output logic              update_dr_o
);

  localparam logic [3:0] TLR   = 4'hF, RTI   = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
                         SHDR  = 4'h2, EX1DR = 4'h1, PAUDR = 4'h3, EX2DR = 4'h0,
                         UPDDR = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA,
                         EX1IR = 4'h9, PAUIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;

  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] IR_USER   = IR_W'(8);

  logic tms, tdi, step, trst;
  assign tms  = drive_i[0];
  assign tdi  = drive_i[1];
  assign step = drive_i[2];
  assign trst = drive_i[3];

  logic [3:0]        next_state;
  logic [IR_W-1:0]   ir_sh;
  logic [31:0]       id_sh;
  logic              bypass;
  logic [USER_W-1:0] user_sh;
  logic              sel_id, sel_user;

  // Data register selection always follows the committed instruction.
  assign sel_id   = (ir_o == IR_IDCODE);
  assign sel_user = (ir_o == IR_USER);

  // NOTE: every path through a combinational block must assign its outputs;
  // the default at the top prevents a latch for unlisted cases.
  always_comb begin
    next_state = state_o;
    case (state_o)
      TLR:          next_state = tms ? TLR   : RTI;
      RTI:          if (tms) next_state = SELDR;
      SELDR:        next_state = tms ? SELIR : CAPDR;
      SELIR:        next_state = tms ? TLR   : CAPIR;
      CAPDR:        next_state = tms ? EX1DR : SHDR;
      CAPIR:        next_state = tms ? EX1IR : SHIR;
      SHDR:         if (tms) next_state = EX1DR;
      SHIR:         if (tms) next_state = EX1IR;
      EX1DR:        next_state = tms ? UPDDR : PAUDR;
      EX1IR:        next_state = tms ? UPDIR : PAUIR;
      PAUDR:        if (tms) next_state = EX2DR;
      PAUIR:        if (tms) next_state = EX2IR;
      EX2DR:        next_state = tms ? UPDDR : SHDR;
      EX2IR:        next_state = tms ? UPDIR : SHIR;
      UPDDR, UPDIR: next_state = tms ? SELDR : RTI;
      default:      next_state = state_o;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_o     <= TLR;
      ir_o        <= IR_IDCODE;
      ir_sh       <= '0;
      id_sh       <= '0;
      bypass      <= 1'b0;
      user_sh     <= '0;
      user_dr_o   <= '0;
      update_dr_o <= 1'b0;
    end else begin
      update_dr_o <= 1'b0;
      if (trst) begin
        state_o <= TLR;
        ir_o    <= IR_IDCODE;
      end else if (step) begin
        state_o <= next_state;
        case (state_o)
          CAPIR: ir_sh <= IR_W'(1);
          SHIR:  ir_sh <= {tdi, ir_sh[IR_W-1:1]};
          UPDIR: ir_o  <= ir_sh;
          CAPDR: begin
            if (sel_id)        id_sh   <= IDCODE;
            else if (sel_user) user_sh <= user_dr_o;
            else               bypass  <= 1'b0;
          end
          SHDR: begin
            if (sel_id)        id_sh   <= {tdi, id_sh[31:1]};
            else if (sel_user) user_sh <= {tdi, user_sh[USER_W-1:1]};
            else               bypass  <= tdi;
          end
          UPDDR: begin
            if (sel_user) begin
              user_dr_o   <= user_sh;
              update_dr_o <= 1'b1;
            end
          end
          default: ;
        endcase
        // Entering Test-Logic-Reset re-selects IDCODE.
        if (next_state == TLR) ir_o <= IR_IDCODE;
      end
    end
  end

  always_comb begin
    tdo_o = 1'b0;
    if (state_o == SHIR) begin
      tdo_o = ir_sh[0];
    end else if (state_o == SHDR) begin
      if (sel_id)        tdo_o = id_sh[0];
      else if (sel_user) tdo_o = user_sh[0];
      else               tdo_o = bypass;
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Scoreboard bench for jtag_tap: a table-driven TAP model predicts every
// cycle's outputs, a monitor process compares them against the DUT.
module tb_jtag_tap;

  localparam int IR_W = 4;
  localparam int USER_W = 8;
  localparam logic [31:0] ID = 32'h1BA0_0477;

  localparam int TLR = 15, RTI = 12, SELDR = 7, CAPDR = 6, SHDR = 2, EX1DR = 1,
                 PAUDR = 3, EX2DR = 0, UPDDR = 5, SELIR = 4, CAPIR = 14,
                 SHIR = 10, EX1IR = 9, PAUIR = 11, EX2IR = 8, UPDIR = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        drive_i = 4'h0;
  logic [3:0]        state_o;
  logic              tdo_o;
  logic [IR_W-1:0]   ir_o;
  logic [USER_W-1:0] user_dr_o;
  logic              update_dr_o;

  jtag_tap #(.IR_W(IR_W), .IDCODE(ID), .USER_W(USER_W)) dut (
    .clk(clk), .rst(rst), .drive_i(drive_i), .state_o(state_o), .tdo_o(tdo_o),
    .ir_o(ir_o), .user_dr_o(user_dr_o), .update_dr_o(update_dr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       tdo;
    logic [3:0] ir;
    logic [7:0] udr;
    logic       upd;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  // Reference model: transition table plus integer shift registers.
  int          nxt[16][2];
  int          m_state;
  int unsigned m_ir, m_irsh, m_id, m_byp, m_ush, m_udr, m_upd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = TLR; m_ir = 1; m_irsh = 0; m_id = 0; m_byp = 0;
    m_ush = 0; m_udr = 0; m_upd = 0;
  endfunction

  function automatic void model_step(input bit tms, input bit tdi, input bit en, input bit trst);
    int unsigned t = tdi;
    m_upd = 0;
    if (trst) begin
      m_state = TLR; m_ir = 1;
      return;
    end
    if (!en) return;
    if (m_state == CAPIR) m_irsh = 1;
    if (m_state == SHIR)  m_irsh = (m_irsh >> 1) + t * (1 << (IR_W - 1));
    if (m_state == UPDIR) m_ir = m_irsh;
    if (m_state == CAPDR) begin
      if (m_ir == 1) m_id = ID;
      else if (m_ir == 8) m_ush = m_udr;
      else m_byp = 0;
    end
    if (m_state == SHDR) begin
      if (m_ir == 1) m_id = (m_id >> 1) + t * 32'h8000_0000;
      else if (m_ir == 8) m_ush = (m_ush >> 1) + t * (1 << (USER_W - 1));
      else m_byp = t;
    end
    if (m_state == UPDDR && m_ir == 8) begin
      m_udr = m_ush; m_upd = 1;
    end
    m_state = nxt[m_state][tms];
    if (m_state == TLR) m_ir = 1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st = 4'(m_state); e.ir = 4'(m_ir); e.udr = 8'(m_udr); e.upd = 1'(m_upd);
    e.tdo = 1'b0;
    if (m_state == SHIR) e.tdo = 1'(m_irsh % 2);
    if (m_state == SHDR) begin
      if (m_ir == 1) e.tdo = 1'(m_id % 2);
      else if (m_ir == 8) e.tdo = 1'(m_ush % 2);
      else e.tdo = 1'(m_byp);
    end
    return e;
  endfunction

  // One clk cycle of stimulus; returns tdo as seen just before this step.
  task automatic do_step(input bit tms, input bit tdi, input bit en, input bit trst,
                         output logic tdo_s);
    @(negedge clk);
    tdo_s = tdo_o;
    rst = 1'b0;
    drive_i = {trst, en, tdi, tms};
    model_step(tms, tdi, en, trst);
    sbq.push_back(model_out());
  endtask

  task automatic st(input bit tms);
    logic d;
    do_step(tms, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic idle();
    logic d;
    do_step(1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_i = 4'h0;
    model_reset();
    sbq.push_back(model_out());
  endtask

  task automatic shift(input logic [31:0] data, input int n, output logic [31:0] got);
    logic t;
    got = '0;
    for (int i = 0; i < n; i++) begin
      do_step(i == n - 1, data[i], 1'b1, 1'b0, t);
      got[i] = t;
    end
  endtask

  task automatic goto_shdr();  // from RTI
    st(1); st(0); st(0);
  endtask

  task automatic load_ir(input logic [3:0] v);  // from RTI, back to RTI
    logic [31:0] got;
    st(1); st(1); st(0); st(0);
    shift({28'h0, v}, IR_W, got);
    check("ir_capture", got, 32'h1);
    st(1); st(0);
  endtask

  // Monitor: compare one predicted cycle shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("state", 32'(state_o), 32'(e.st));
        check("tdo", 32'(tdo_o), 32'(e.tdo));
        check("ir", 32'(ir_o), 32'(e.ir));
        check("user_dr", 32'(user_dr_o), 32'(e.udr));
        check("update_dr", 32'(update_dr_o), 32'(e.upd));
      end
    end
  end

  initial begin
    logic [31:0] got;
    logic        d;
    for (int s = 0; s < 16; s++) begin
      nxt[s][0] = s; nxt[s][1] = s;
    end
    nxt[TLR]   = '{RTI, TLR};     nxt[RTI][1] = SELDR;
    nxt[SELDR] = '{CAPDR, SELIR}; nxt[SELIR] = '{CAPIR, TLR};
    nxt[CAPDR] = '{SHDR, EX1DR};  nxt[CAPIR] = '{SHIR, EX1IR};
    nxt[SHDR][1] = EX1DR;         nxt[SHIR][1] = EX1IR;
    nxt[EX1DR] = '{PAUDR, UPDDR}; nxt[EX1IR] = '{PAUIR, UPDIR};
    nxt[PAUDR][1] = EX2DR;        nxt[PAUIR][1] = EX2IR;
    nxt[EX2DR] = '{SHDR, UPDDR};  nxt[EX2IR] = '{SHIR, UPDIR};
    nxt[UPDDR] = '{RTI, SELDR};   nxt[UPDIR] = '{RTI, SELDR};

    model_reset();
    apply_reset();
    repeat (5) st(1);

    // IDCODE readout straight after reset.
    st(0); goto_shdr();
    shift(32'h0, 32, got);
    check("idcode_stream", got, ID);
    st(1); st(0);

    // BYPASS: one-bit delay.
    load_ir(4'hF); goto_shdr();
    shift(32'hD, 4, got);
    check("bypass_stream", got, 32'hA);
    st(1); st(0);

    // USER register write, update pulse, recapture.
    load_ir(4'h8); goto_shdr();
    shift(32'hA5, 8, got);
    st(1); st(0); idle();
    check("user_written", 32'(user_dr_o), 32'hA5);
    check("update_pulse", 32'(update_dr_o), 32'h1);
    idle();
    check("update_drop", 32'(update_dr_o), 32'h0);
    goto_shdr();
    shift(32'hA5, 8, got);
    check("user_recapture", got, 32'hA5);
    st(1); st(0);

    // Test reset mid-shift, without step enable.
    goto_shdr();
    shift(32'h3, 3, got);
    st(0); st(0);  // from Ex1DR via Pause back toward Shift
    do_step(1'b0, 1'b1, 1'b0, 1'b1, d);
    idle();
    check("trst_state", 32'(state_o), 32'hF);
    check("trst_ir", 32'(ir_o), 32'h1);
    check("trst_user", 32'(user_dr_o), 32'hA5);

    // Asynchronous reset mid-shift.
    st(0); load_ir(4'h8); goto_shdr();
    do_step(1'b0, 1'b1, 1'b1, 1'b0, d);
    do_step(1'b0, 1'b0, 1'b1, 1'b0, d);
    apply_reset();
    idle();
    check("rst_user", 32'(user_dr_o), 32'h0);
    check("rst_ir", 32'(ir_o), 32'h1);

    // Step enable low: nothing moves.
    st(0); goto_shdr();
    do_step(1'b0, 1'b1, 1'b1, 1'b0, d);
    for (int i = 0; i < 10; i++)
      do_step(1'($urandom), 1'($urandom), 1'b0, 1'b0, d);
    check("hold_state", 32'(state_o), 32'h2);

    // Random walk through the whole state graph.
    for (int i = 0; i < 600; i++)
      do_step(1'($urandom), 1'($urandom), $urandom_range(3, 0) != 0,
              $urandom_range(40, 0) == 0, d);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
